// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_pkg
// Purpose  : Shared constants for the up/down modulus counter: default data
//            width and the encoding of the up_dn direction input.
// Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

    // Default counter / data width in bits.
    localparam int COUNTER_WIDTH = 8;

    // Encoding of the up_dn input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : counter_pkg
`default_nettype wire

// File: rtl/updn_mod_counter_next.sv
`default_nettype none
// ============================================================================
// Module   : updn_mod_counter_next
// Purpose  : Combinational next-count and wrap detection for the up/down
//            modulus counter. Holds no state.
// Ports    : count   (in,  WIDTH) current count
//            modulus (in,  WIDTH) terminal value, count range 0..modulus
//            up_dn   (in,  1)     1 = up, 0 = down
//            next    (out, WIDTH) next count (wrap target on a wrap event)
//            wrap    (out, 1)     the step would cross the terminal value
// Revision : 1.0 - initial release
// ============================================================================
module updn_mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] modulus,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        next = count;
        wrap = 1'b0;
        if (up_dn == DIR_UP) begin
            // count >= modulus (including count above a lowered modulus,
            // and modulus = 0) is a wrap back to zero.
            if (count < modulus) begin
                next = count + ONE;
            end else begin
                wrap = 1'b1;
                next = '0;
            end
        end else begin
            // Counting down only wraps at zero; a count above modulus just
            // decrements until it re-enters the range.
            if (count != '0) begin
                next = count - ONE;
            end else begin
                wrap = 1'b1;
                next = modulus;
            end
        end
    end

endmodule : updn_mod_counter_next
`default_nettype wire

// File: rtl/updn_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updn_mod_counter
// Purpose  : Loadable up/down counter with run-time modulus, one-shot or
//            wrap mode, registered terminal-count pulse and optional count
//            snapshot (capture) feature.
// Config   : define UPDN_MOD_COUNTER_CAPTURE_EN to build the capture logic;
//            otherwise capture is ignored and cap_value/cap_valid read 0.
// Ports    : clk           (in)         clock, rising edge
//            rst           (in)         asynchronous active-high reset
//            load          (in)         synchronous load of base_count
//            base_count    (in,  WIDTH) load value
//            en            (in)         count enable
//            up_dn         (in)         1 = up, 0 = down
//            modulus       (in,  WIDTH) terminal value
//            one_shot      (in)         1 = stop at terminal, 0 = wrap
//            out_en        (in)         gate for counter_state
//            counter_state (out, WIDTH) count, or zero when out_en = 0
//            tc            (out)        registered terminal-count pulse
//            halted        (out)        one-shot run finished
//            capture       (in)         snapshot request
//            cap_value     (out, WIDTH) captured count
//            cap_valid     (out)        one-cycle pulse on cap_value update
// Revision : 1.0 - initial release
// ============================================================================
module updn_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] base_count,
    input  logic             en,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] modulus,
    input  logic             one_shot,
    input  logic             out_en,
    output logic [WIDTH-1:0] counter_state,
    output logic             tc,
    output logic             halted,
    input  logic             capture,
    output logic [WIDTH-1:0] cap_value,
    output logic             cap_valid
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             halted_q, halted_d;
    logic [WIDTH-1:0] step_next;
    logic             step_wrap;

    updn_mod_counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .count   (count_q),
        .modulus (modulus),
        .up_dn   (up_dn),
        .next    (step_next),
        .wrap    (step_wrap)
    );

    // Priority: load > (en and not halted) > hold. tc is only ever set by
    // a processed wrap, so it is a single-cycle pulse and cannot repeat
    // while halted because halted blocks further steps.
    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        halted_d = halted_q;
        if (load) begin
            count_d  = base_count;
            halted_d = 1'b0;
        end else if (en && !halted_q) begin
            if (step_wrap) begin
                tc_d = 1'b1;
                if (one_shot) begin
                    halted_d = 1'b1;  // count stays at the terminal value
                end else begin
                    count_d = step_next;
                end
            end else begin
                count_d = step_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            tc_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            tc_q     <= tc_d;
            halted_q <= halted_d;
        end
    end

    assign counter_state = out_en ? count_q : '0;
    assign tc            = tc_q;
    assign halted        = halted_q;

`ifdef UPDN_MOD_COUNTER_CAPTURE_EN
    logic [WIDTH-1:0] cap_value_q, cap_value_d;
    logic             cap_valid_q, cap_valid_d;

    // Snapshot takes the pre-edge count, so it is independent of any load
    // or step happening on the same edge.
    always_comb begin
        cap_value_d = cap_value_q;
        cap_valid_d = capture;
        if (capture) begin
            cap_value_d = count_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_value_q <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            cap_value_q <= cap_value_d;
            cap_valid_q <= cap_valid_d;
        end
    end

    assign cap_value = cap_value_q;
    assign cap_valid = cap_valid_q;
`else
    // Capture is not built; the port is kept but deliberately unused.
    logic unused_capture;
    assign unused_capture = capture;
    assign cap_value      = '0;
    assign cap_valid      = 1'b0;
`endif

endmodule : updn_mod_counter
`default_nettype wire

// File: tb/tb_updn_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updn_mod_counter
// Purpose  : Directed self-checking bench for updn_mod_counter (WIDTH = 8).
//            Capture expectations follow UPDN_MOD_COUNTER_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updn_mod_counter;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         load;
    logic [W-1:0] base_count;
    logic         en;
    logic         up_dn;
    logic [W-1:0] modulus;
    logic         one_shot;
    logic         out_en;
    logic [W-1:0] counter_state;
    logic         tc;
    logic         halted;
    logic         capture;
    logic [W-1:0] cap_value;
    logic         cap_valid;

    int n_checks = 0;
    int n_fail   = 0;

    updn_mod_counter #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .load          (load),
        .base_count    (base_count),
        .en            (en),
        .up_dn         (up_dn),
        .modulus       (modulus),
        .one_shot      (one_shot),
        .out_en        (out_en),
        .counter_state (counter_state),
        .tc            (tc),
        .halted        (halted),
        .capture       (capture),
        .cap_value     (cap_value),
        .cap_valid     (cap_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        n_checks++;
        if (counter_state !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", counter_state); end
        n_checks++;
        if (tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc got=%b exp=0", tc); end
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_checks++;
        if (cap_value !== 8'h00 || cap_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_cap got=%h/%b exp=00/0", cap_value, cap_valid);
        end
        rst = 1'b0;
    endtask

    // modulus 9 counting up from 0: 1..9 then 0, tc only after 9 -> 0.
    task automatic test_wrap_up();
        logic [W-1:0] exp;
        modulus = 8'd9; up_dn = 1'b1; one_shot = 1'b0; en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp = (i == 10) ? 8'd0 : 8'(i);
            n_checks++;
            if (counter_state !== exp) begin n_fail++; $display("FAIL wrap_up_count i=%0d got=%h exp=%h", i, counter_state, exp); end
            n_checks++;
            if (tc !== (i == 10)) begin n_fail++; $display("FAIL wrap_up_tc i=%0d got=%b exp=%b", i, tc, (i == 10)); end
        end
        en = 1'b0;
        step();
        n_checks++;
        if (tc !== 1'b0 || counter_state !== 8'd0) begin
            n_fail++; $display("FAIL wrap_up_hold got=%h/%b exp=00/0", counter_state, tc);
        end
    endtask

    // load 3, down, modulus 5, one-shot: 3,2,1,0 then hold with one tc.
    task automatic test_one_shot();
        modulus = 8'd5; up_dn = 1'b0; one_shot = 1'b1; en = 1'b1;
        load = 1'b1; base_count = 8'd3;
        step();
        load = 1'b0;
        n_checks++;
        if (counter_state !== 8'd3 || tc !== 1'b0) begin n_fail++; $display("FAIL oneshot_load got=%h/%b exp=03/0", counter_state, tc); end
        for (int i = 2; i >= 0; i--) begin
            step();
            n_checks++;
            if (counter_state !== 8'(i) || tc !== 1'b0 || halted !== 1'b0) begin
                n_fail++; $display("FAIL oneshot_down got=%h/%b/%b exp=%h/0/0", counter_state, tc, halted, 8'(i));
            end
        end
        step();
        n_checks++;
        if (counter_state !== 8'd0 || tc !== 1'b1 || halted !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_term got=%h/%b/%b exp=00/1/1", counter_state, tc, halted);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (counter_state !== 8'd0 || tc !== 1'b0 || halted !== 1'b1) begin
                n_fail++; $display("FAIL oneshot_held got=%h/%b/%b exp=00/0/1", counter_state, tc, halted);
            end
        end
        load = 1'b1; base_count = 8'd7;
        step();
        load = 1'b0; en = 1'b0;
        n_checks++;
        if (counter_state !== 8'd7 || halted !== 1'b0 || tc !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_reload got=%h/%b/%b exp=07/0/0", counter_state, halted, tc);
        end
    endtask

    // Load wins over a pending wrap; count above modulus wraps up to 0.
    task automatic test_load_priority();
        modulus = 8'd9; up_dn = 1'b1; one_shot = 1'b0; en = 1'b1;
        load = 1'b1; base_count = 8'd9;
        step();
        base_count = 8'h20;
        step();
        load = 1'b0;
        n_checks++;
        if (counter_state !== 8'h20 || tc !== 1'b0) begin n_fail++; $display("FAIL load_prio got=%h/%b exp=20/0", counter_state, tc); end
        step();
        en = 1'b0;
        n_checks++;
        if (counter_state !== 8'h00 || tc !== 1'b1) begin n_fail++; $display("FAIL load_above_mod got=%h/%b exp=00/1", counter_state, tc); end
    endtask

    // modulus 0: count stays 0 and every enabled step is a wrap.
    task automatic test_modulus_zero();
        modulus = 8'd0; up_dn = 1'b1; one_shot = 1'b0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (counter_state !== 8'd0 || tc !== 1'b1) begin n_fail++; $display("FAIL mod0 got=%h/%b exp=00/1", counter_state, tc); end
        end
        en = 1'b0;
    endtask

    // Async reset in mid-cycle at 0x7F with halted set and tc pending.
    task automatic test_async_reset();
        modulus = 8'h7F; up_dn = 1'b1; one_shot = 1'b1; en = 1'b1;
        load = 1'b1; base_count = 8'h7F;
        step();
        load = 1'b0;
        step();
        n_checks++;
        if (counter_state !== 8'h7F || halted !== 1'b1 || tc !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre got=%h/%b/%b exp=7f/1/1", counter_state, halted, tc);
        end
        out_en = 1'b0;
        #1;
        n_checks++;
        if (counter_state !== 8'h00) begin n_fail++; $display("FAIL out_en_gate got=%h exp=00", counter_state); end
        out_en = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (counter_state !== 8'h00 || halted !== 1'b0 || tc !== 1'b0) begin
            n_fail++; $display("FAIL areset_mid got=%h/%b/%b exp=00/0/0", counter_state, halted, tc);
        end
        #1;
        rst = 1'b0; one_shot = 1'b0;
        step();
        en = 1'b0;
        n_checks++;
        if (counter_state !== 8'h01 || halted !== 1'b0) begin
            n_fail++; $display("FAIL areset_first_step got=%h/%b exp=01/0", counter_state, halted);
        end
    endtask

    task automatic test_capture();
        load = 1'b1; base_count = 8'h42; en = 1'b0;
        step();
        load = 1'b0; capture = 1'b1;
        step();
        capture = 1'b0;
`ifdef UPDN_MOD_COUNTER_CAPTURE_EN
        n_checks++;
        if (cap_value !== 8'h42 || cap_valid !== 1'b1) begin n_fail++; $display("FAIL capture got=%h/%b exp=42/1", cap_value, cap_valid); end
`else
        n_checks++;
        if (cap_value !== 8'h00 || cap_valid !== 1'b0) begin n_fail++; $display("FAIL capture_off got=%h/%b exp=00/0", cap_value, cap_valid); end
`endif
        step();
`ifdef UPDN_MOD_COUNTER_CAPTURE_EN
        n_checks++;
        if (cap_value !== 8'h42 || cap_valid !== 1'b0) begin n_fail++; $display("FAIL capture_after got=%h/%b exp=42/0", cap_value, cap_valid); end
`else
        n_checks++;
        if (cap_value !== 8'h00 || cap_valid !== 1'b0) begin n_fail++; $display("FAIL capture_off_after got=%h/%b exp=00/0", cap_value, cap_valid); end
`endif
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; base_count = '0; en = 1'b0; up_dn = 1'b1;
        modulus = '0; one_shot = 1'b0; out_en = 1'b1; capture = 1'b0;
        test_reset();
        test_wrap_up();
        test_one_shot();
        test_load_priority();
        test_modulus_zero();
        test_async_reset();
        test_capture();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_updn_mod_counter
`default_nettype wire

// File: doc/updn_mod_counter.md
UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width in bits (min 2).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on posedge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port load, input, 1, synchronous load of base_count.
REQ-005 SHALL have port base_count, input, WIDTH, load value.
REQ-006 SHALL have port en, input, 1, count enable.
REQ-007 SHALL have port up_dn, input, 1, direction: 1 = up, 0 = down.
REQ-008 SHALL have port modulus, input, WIDTH, terminal value: count range 0..modulus.
REQ-009 SHALL have port one_shot, input, 1: 1 = stop at terminal, 0 = wrap.
REQ-010 SHALL have port out_en, input, 1, output enable for counter_state.
REQ-011 SHALL have port counter_state, output, WIDTH: count when out_en = 1, else all zeros (no tri-state).
REQ-012 SHALL have port tc, output, 1, registered terminal-count pulse.
REQ-013 SHALL have port halted, output, 1, one-shot finished flag.
REQ-014 SHALL have port capture, input, 1, snapshot request.
REQ-015 SHALL have port cap_value, output, WIDTH, captured count.
REQ-016 SHALL have port cap_valid, output, 1, one-cycle pulse when cap_value updates.

Function
REQ-017 SHALL update count with priority load > (en and not halted) > hold.
REQ-018 SHALL, on load, set count = base_count, clear halted, and force tc = 0 that cycle, regardless of en or a pending wrap.
REQ-019 SHALL, on up step, set next = count+1 if count < modulus, else a wrap event (this covers count > modulus after a load or a modulus change).
REQ-020 SHALL, on down step, set next = count-1 if count != 0, else a wrap event; count > modulus decrements normally.
REQ-021 SHALL, on a wrap event with one_shot = 0, set next = 0 when counting up or modulus when counting down.
REQ-022 SHALL, on a wrap event with one_shot = 1, hold count (terminal value unchanged) and set halted = 1.
REQ-023 SHALL assert tc for exactly one clk in the cycle after the edge that processed the wrap event; tc SHALL NOT pulse again while halted.
REQ-024 SHALL treat modulus = 0 as: count stays 0 and every enabled step is a wrap event.
REQ-025 SHALL sample up_dn, modulus and one_shot each cycle; changes take effect on the next step with no latency.
REQ-026 SHALL use modulo-2^WIDTH arithmetic; no carry or borrow is exposed.
REQ-027 SHALL make counter_state combinational from count and out_en (zero latency).

Reset
REQ-028 SHALL, while rst = 1, immediately force count = 0, tc = 0, halted = 0, cap_value = 0 and cap_valid = 0.
REQ-029 SHALL abort any one-shot run or pending tc when rst is asserted mid-operation; the first step occurs on the first posedge after rst deasserts.

Configuration
REQ-030 SHALL compile in the capture feature only when macro UPDN_MOD_COUNTER_CAPTURE_EN is defined.
REQ-031 SHALL, with UPDN_MOD_COUNTER_CAPTURE_EN defined: when capture = 1 at a posedge, load cap_value with the pre-edge count and pulse cap_valid for 1 cycle; capture works during load and while halted.
REQ-032 SHALL, without UPDN_MOD_COUNTER_CAPTURE_EN: keep all ports present, ignore capture, and tie cap_value = 0 and cap_valid = 0.

Structure
REQ-033 SHALL define in shared package counter_pkg: the WIDTH default (8) and direction constants DIR_UP = 1 and DIR_DOWN = 0.
REQ-034 SHALL place next-count and wrap-detect logic in combinational sub-module updn_mod_counter_next (inputs count, modulus, up_dn; outputs next, wrap); registers stay in the top module.

Verification (WIDTH = 8)
REQ-035 SHALL cover: modulus = 9, up, en = 1 from 0 -> sequence 0..9,0; tc high only in the cycle after 9 -> 0.
REQ-036 SHALL cover: load base_count = 3, down, modulus = 5, one_shot = 1 -> 3,2,1,0, hold 0; halted = 1; single tc pulse; next load = 7 clears halted.
REQ-037 SHALL cover: count = 9, modulus = 9, up, load = 1 with base_count = 0x20 -> count = 0x20 and tc = 0; next step wraps to 0 with tc pulse.
REQ-038 SHALL cover: rst asserted asynchronously mid-cycle at count = 0x7F -> count = 0, halted = 0 and tc = 0 before the next edge; out_en = 0 -> counter_state = 0x00.
REQ-039 SHALL cover: with the macro, capture at count = 0x42 -> cap_value = 0x42 and one cap_valid pulse; without the macro, cap_value = 0 and cap_valid = 0 always.
